// File: rtl/ws_systolic_engine.sv
// Weight-stationary ROW x COL systolic matrix-vector engine with input skew,
// output deskew, weight-load sequencer and credit-guarded result FIFO.
module ws_systolic_engine #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20,
  parameter int ROW       = 4,
  parameter int COL       = 4,
  parameter int OUT_DEPTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wt_valid_i,
  output logic                    wt_ready_o,
  input  logic [COL*DATA_W-1:0]   wt_data_i,
  input  logic                    act_valid_i,
  output logic                    act_ready_o,
  input  logic [ROW*DATA_W-1:0]   act_data_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [COL*ACC_W-1:0]    res_data_o,
  output logic                    busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COMP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int RW  = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int PL  = ROW + COL;
  localparam int SKN = ROW * (ROW + 1) / 2;
  localparam int DKN = COL * (COL - 1) / 2;

  // Skew and deskew delay lines are packed as triangles in flat arrays.
  function automatic int sb(input int r);
    return r * (r + 1) / 2;
  endfunction

  function automatic int db(input int c);
    return c * (COL - 1) - c * (c - 1) / 2;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PL-1:0] vld_q, vld_d;

  logic signed [DATA_W-1:0] w_q  [ROW][COL];
  logic signed [DATA_W-1:0] w_d  [ROW][COL];
  logic signed [DATA_W-1:0] sk_q [SKN];
  logic signed [DATA_W-1:0] sk_d [SKN];
  logic signed [DATA_W-1:0] a_q  [ROW][COL-1];
  logic signed [DATA_W-1:0] a_d  [ROW][COL-1];
  logic signed [DATA_W-1:0] a_x  [ROW][COL];
  logic signed [ACC_W-1:0]  p_q  [ROW][COL];
  logic signed [ACC_W-1:0]  p_d  [ROW][COL];
  logic signed [ACC_W-1:0]  dk_q [DKN];
  logic signed [ACC_W-1:0]  dk_d [DKN];

  logic [COL*ACC_W-1:0] mem_q [OUT_DEPTH];
  logic [COL*ACC_W-1:0] push_data;

  logic          wt_acc, act_acc, push, pop, credit;
  logic [RW-1:0] wrow;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wt_ready_o  = 1'b0;
    act_ready_o = 1'b0;
    credit      = ({1'b0, infl_q} + {1'b0, fcnt_q})
                  < (CW+1)'(OUT_DEPTH);
    unique case (state_q)
      S_IDLE: begin
        wt_ready_o = 1'b1;
        if (wt_valid_i) begin
          cnt_d   = RW'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wt_ready_o = 1'b1;
        if (wt_valid_i) begin
          if (cnt_q == RW'(ROW - 1)) begin
            cnt_d   = '0;
            state_d = S_COMP;
          end else begin
            cnt_d = cnt_q + RW'(1);
          end
        end
      end
      S_COMP: begin
        act_ready_o = credit;
        if (wt_valid_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (infl_q == '0) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wt_acc  = wt_valid_i & wt_ready_o;
  assign act_acc = act_valid_i & act_ready_o;
  assign wrow    = (state_q == S_IDLE) ? '0 : cnt_q;

  always_comb begin
    w_d = w_q;
    if (wt_acc) begin
      for (int c = 0; c < COL; c++)
        w_d[wrow][c] = wt_data_i[c*DATA_W +: DATA_W];
    end
  end

  // Bubbles carry zero activations, so they add nothing to the wavefront.
  always_comb begin
    sk_d      = sk_q;
    a_d       = a_q;
    p_d       = p_q;
    dk_d      = dk_q;
    a_x       = '{default: '0};
    push_data = '0;
    for (int r = 0; r < ROW; r++) begin
      sk_d[sb(r)] = act_acc ? act_data_i[r*DATA_W +: DATA_W] : '0;
      for (int k = 1; k <= r; k++)
        sk_d[sb(r)+k] = sk_q[sb(r)+k-1];
      a_x[r][0] = sk_q[sb(r)+r];
      for (int c = 1; c < COL; c++)
        a_x[r][c] = a_q[r][c-1];
      for (int c = 0; c < COL - 1; c++)
        a_d[r][c] = a_x[r][c];
    end
    for (int c = 0; c < COL; c++) begin
      p_d[0][c] = ACC_W'(a_x[0][c]) * ACC_W'(w_q[0][c]);
      for (int r = 1; r < ROW; r++)
        p_d[r][c] = p_q[r-1][c]
                  + ACC_W'(a_x[r][c]) * ACC_W'(w_q[r][c]);
    end
    for (int c = 0; c < COL - 1; c++) begin
      dk_d[db(c)] = p_q[ROW-1][c];
      for (int k = 1; k < COL - 1 - c; k++)
        dk_d[db(c)+k] = dk_q[db(c)+k-1];
      push_data[c*ACC_W +: ACC_W] = dk_q[db(c)+COL-2-c];
    end
    push_data[(COL-1)*ACC_W +: ACC_W] = p_q[ROW-1][COL-1];
  end

  assign vld_d       = {vld_q[PL-2:0], act_acc};
  assign push        = vld_q[PL-1];
  assign res_valid_o = (fcnt_q != '0);
  assign pop         = res_valid_o & res_ready_i;
  assign res_data_o  = res_valid_o ? mem_q[rd_q] : '0;
  assign busy_o      = (state_q != S_IDLE) | res_valid_o
                     | (infl_q != '0);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    infl_d = infl_q;
    if (push)
      wr_d = (wr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (pop)
      rd_d = (rd_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_q + PW'(1);
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
    unique case ({act_acc, push})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      infl_q  <= '0;
      fcnt_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      vld_q   <= '0;
      w_q     <= '{default: '0};
      sk_q    <= '{default: '0};
      a_q     <= '{default: '0};
      p_q     <= '{default: '0};
      dk_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      infl_q  <= infl_d;
      fcnt_q  <= fcnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
      w_q     <= w_d;
      sk_q    <= sk_d;
      a_q     <= a_d;
      p_q     <= p_d;
      dk_q    <= dk_d;
    end
  end

endmodule

// File: tb/tb_ws_systolic_engine.sv
// Scoreboard bench for ws_systolic_engine: expected vectors come from a
// plain integer matrix-vector model and are popped by a result monitor.
module tb_ws_systolic_engine;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int D  = 16;

  logic          clk, rst;
  logic          wt_valid, wt_ready;
  logic [C*DW-1:0] wt_data;
  logic          act_valid, act_ready;
  logic [R*DW-1:0] act_data;
  logic          res_valid, res_ready;
  logic [C*AW-1:0] res_data;
  logic          busy;

  ws_systolic_engine #(
    .DATA_W(DW), .ACC_W(AW), .ROW(R), .COL(C), .OUT_DEPTH(D)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wt_valid_i(wt_valid), .wt_ready_o(wt_ready),
    .wt_data_i(wt_data),
    .act_valid_i(act_valid), .act_ready_o(act_ready),
    .act_data_i(act_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .busy_o(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wm [R][C];
  logic [C*AW-1:0] sbq [$];
  int pop_cyc_q [$];
  bit rnd_rr = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [C*AW-1:0] model(input logic [R*DW-1:0] x);
    logic [C*AW-1:0] y;
    longint s;
    logic signed [DW-1:0] xv;
    y = '0;
    for (int c = 0; c < C; c++) begin
      s = 0;
      for (int r = 0; r < R; r++) begin
        xv = x[r*DW +: DW];
        s += longint'(xv) * longint'(wm[r][c]);
      end
      y[c*AW +: AW] = s[AW-1:0];
    end
    return y;
  endfunction

  function automatic int wval(input int mode, input int r, input int c);
    case (mode)
      0:       return (r == c) ? 1 : 0;
      1:       return -128;
      2:       return 1;
      3:       return int'($urandom_range(0, 255)) - 128;
      default: return r + 2 * c - 3;
    endcase
  endfunction

  function automatic logic [R*DW-1:0] vec4(input int a, input int b,
                                            input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [R*DW-1:0] rvec();
    logic [R*DW-1:0] v;
    for (int r = 0; r < R; r++) v[r*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Result monitor: decoupled from stimulus, pops on every transfer.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h want none", res_data);
      end else begin
        chk("result", res_data, sbq.pop_front());
      end
      pop_cyc_q.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    if (rnd_rr) begin
      #1;
      res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic load_w(input int mode, input bit chk_noact);
    int row [C];
    bit ok;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        row[c] = wval(mode, r, c);
        wt_data[c*DW +: DW] = DW'(row[c]);
      end
      wt_valid = 1;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (chk_noact) chk("act_ready_low_in_load", act_ready, 0);
        if (wt_ready) begin
          ok = 1;
          for (int c = 0; c < C; c++) wm[r][c] = row[c];
        end
        @(posedge clk); #1;
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL wt_timeout: got no wt_ready want beat %0d", r);
      end
    end
    wt_valid = 0;
  endtask

  task automatic send_vec(input logic [R*DW-1:0] x, input int budget,
                          output bit ok, output int acc);
    act_data  = x;
    act_valid = 1;
    ok  = 0;
    acc = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (act_ready) begin
        ok  = 1;
        acc = cyc + 1;
        sbq.push_back(model(x));
      end
      @(posedge clk); #1;
    end
    act_valid = 0;
  endtask

  task automatic wait_empty(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !res_valid) done = 1;
    end
    chk("drain_done", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int acc, got, k, stall, stale;
    logic [R*DW-1:0] v6;

    rst = 1; wt_valid = 0; wt_data = '0;
    act_valid = 0; act_data = '0; res_ready = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wt_ready", wt_ready, 1);
    chk("rst_act_ready", act_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    rst = 0;

    // identity weights and fixed latency
    load_w(0, 0);
    @(negedge clk);
    chk("act_ready_compute", act_ready, 1);
    chk("busy_compute", busy, 1);
    @(posedge clk); #1;
    res_ready = 1;
    send_vec(vec4(1, 2, 3, 4), 10, ok, acc);
    chk("accept_first", ok, 1);
    got = -1;
    for (int i = 0; i < 30 && got < 0; i++) begin
      @(negedge clk);
      if (res_valid) got = cyc;
    end
    chk("latency", got, acc + R + C);
    @(posedge clk); #1;
    wait_empty(40);

    // extreme values
    load_w(1, 0);
    send_vec(vec4(-128, -128, -128, -128), 20, ok, acc);
    chk("accept_neg", ok, 1);
    load_w(2, 0);
    send_vec(vec4(127, -128, 1, 0), 20, ok, acc);
    chk("accept_cancel", ok, 1);
    wait_empty(60);

    // credit limit with a blocked consumer
    load_w(0, 0);
    res_ready = 0;
    k = 0;
    while (k < 20) begin
      send_vec(vec4(k, 0, 0, 0), 5, ok, acc);
      if (!ok) break;
      k++;
    end
    chk("credit_accepted", k, D);
    @(negedge clk);
    chk("act_ready_full", act_ready, 0);
    chk("fifo_valid_full", res_valid, 1);
    @(posedge clk); #1;
    res_ready = 1;
    while (k < 20) begin
      send_vec(vec4(k, 0, 0, 0), 50, ok, acc);
      chk("accept_after_drain", ok, 1);
      k++;
    end
    wait_empty(80);

    // back-to-back throughput
    pop_cyc_q.delete();
    stall = 0;
    for (int i = 0; i < 10; i++) begin
      send_vec(rvec(), 1, ok, acc);
      if (!ok) stall++;
    end
    chk("b2b_no_stall", stall, 0);
    wait_empty(40);
    chk("b2b_pops", pop_cyc_q.size(), 10);
    if (pop_cyc_q.size() >= 10)
      chk("b2b_contiguous", pop_cyc_q[9] - pop_cyc_q[0], 9);

    // random weights, gaps and back-pressure
    load_w(3, 0);
    rnd_rr = 1;
    for (int i = 0; i < 40; i++) begin
      send_vec(rvec(), 200, ok, acc);
      chk("rand_accept", ok, 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rnd_rr = 0;
    @(posedge clk); #2;
    res_ready = 1;
    wait_empty(200);

    // weight reload mid-stream
    for (int i = 0; i < 4; i++) send_vec(rvec(), 5, ok, acc);
    for (int c = 0; c < C; c++) wt_data[c*DW +: DW] = DW'(wval(4, 0, c));
    wt_valid = 1;
    send_vec(rvec(), 1, ok, acc);
    chk("accept_with_wt_valid", ok, 1);
    v6 = vec4(3, -7, 11, 2);
    act_data  = v6;
    act_valid = 1;
    @(negedge clk);
    chk("act_ready_drop", act_ready, 0);
    @(posedge clk); #1;
    load_w(4, 1);
    send_vec(v6, 10, ok, acc);
    chk("accept_new_w", ok, 1);
    wait_empty(60);

    // reset with vectors in flight
    for (int i = 0; i < 3; i++) send_vec(rvec(), 5, ok, acc);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_wt_ready", wt_ready, 1);
    chk("mid_rst_act_ready", act_ready, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_busy", busy, 0);
    sbq.delete();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) stale++;
    end
    chk("no_stale_result", stale, 0);
    @(posedge clk); #1;
    act_data  = vec4(5, 6, 7, 8);
    act_valid = 1;
    load_w(0, 1);
    send_vec(vec4(5, 6, 7, 8), 10, ok, acc);
    chk("accept_after_rst", ok, 1);
    wait_empty(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
